// File: rtl/ucisc_mem_pkg.sv
// Shared constants and types for the banked row memory.
//   DEF_DATA_W / DEF_ADDR_W / DEF_BANK_BITS : default geometry
//   row_state_t : row-engine FSM encoding
package ucisc_mem_pkg;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_BANK_BITS = 2;

    typedef enum logic [1:0] {
        ROW_IDLE     = 2'd0,
        ROW_RD_ISSUE = 2'd1,
        ROW_RD_RESP  = 2'd2,
        ROW_WR       = 2'd3
    } row_state_t;
endpackage

// File: rtl/memory_bank_dp.sv
// One memory bank: dual-port, 1-cycle synchronous read on both ports,
// write on port B only. Both ports read-before-write.
// Ports:
//   clock            rising-edge clock
//   a_en / a_idx     port A read enable / word index, a_q read data
//   b_en / b_we      port B access enable / write enable
//   b_idx / b_wdata  port B word index / write data, b_q read data
// Contents are never reset.
module memory_bank_dp
    import ucisc_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_ADDR_W - DEF_BANK_BITS
) (
    input  logic              clock,
    input  logic              a_en,
    input  logic [IDX_W-1:0]  a_idx,
    output logic [DATA_W-1:0] a_q,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_q
);
    logic [DATA_W-1:0] mem [0:(1<<IDX_W)-1];

    always_ff @(posedge clock) begin
        if (a_en) a_q <= mem[a_idx];
        if (b_en) begin
            b_q <= mem[b_idx];
            if (b_we) mem[b_idx] <= b_wdata;
        end
    end
endmodule

// File: rtl/memory_banked_row.sv
// Banked word memory with two word ports and a full-row engine.
// Ports:
//   clock, reset_n                 clock / async active-low reset
//   a_rd_en, a_addr -> a_valid, a_data              port A word reads (never stalled)
//   b_rd_en, b_we, b_addr, b_wdata -> b_stall, b_valid, b_data   port B word access
//   row_req_valid/ready/write/addr, row_wdata       row request
//   row_rsp_valid/ready, row_rdata                  row read response
// Row layout: bank 0 in the MSBs down to bank BANKS-1 in the LSBs.
//
// state        | meaning
// ROW_IDLE     | accepting row requests, port B free
// ROW_RD_ISSUE | row read issued to every bank via port B
// ROW_RD_RESP  | row_rdata valid, waiting for row_rsp_ready
// ROW_WR       | latched row written to every bank via port B
module memory_banked_row
    import ucisc_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BANK_BITS = DEF_BANK_BITS
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               a_rd_en,
    input  logic [ADDR_W-1:0]                  a_addr,
    output logic                               a_valid,
    output logic [DATA_W-1:0]                  a_data,
    input  logic                               b_rd_en,
    input  logic                               b_we,
    input  logic [ADDR_W-1:0]                  b_addr,
    input  logic [DATA_W-1:0]                  b_wdata,
    output logic                               b_stall,
    output logic                               b_valid,
    output logic [DATA_W-1:0]                  b_data,
    input  logic                               row_req_valid,
    output logic                               row_req_ready,
    input  logic                               row_req_write,
    input  logic [ADDR_W-BANK_BITS-1:0]        row_req_addr,
    input  logic [DATA_W*(2**BANK_BITS)-1:0]   row_wdata,
    output logic                               row_rsp_valid,
    input  logic                               row_rsp_ready,
    output logic [DATA_W*(2**BANK_BITS)-1:0]   row_rdata
);
    localparam int BANKS = 2**BANK_BITS;
    localparam int ROW_W = DATA_W*BANKS;
    localparam int IDX_W = ADDR_W-BANK_BITS;

    row_state_t state, state_nxt;
    logic row_hs, row_busy, is_wr, b_wr_ok, b_rd_ok, rsp_first;
    logic [IDX_W-1:0]     row_addr_q;
    logic [ROW_W-1:0]     row_wdata_q, row_cat, row_hold;
    logic [BANK_BITS-1:0] a_sel_q, b_sel_q;
    logic [DATA_W-1:0]    a_hold, b_hold;
    logic [DATA_W-1:0]    a_q [BANKS];
    logic [DATA_W-1:0]    b_q [BANKS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ROW_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        row_req_ready = 1'b0;
        row_rsp_valid = 1'b0;
        row_hs        = 1'b0;
        case (state)
            ROW_IDLE: begin
                row_req_ready = 1'b1;
                if (row_req_valid) begin
                    row_hs    = 1'b1;
                    state_nxt = row_req_write ? ROW_WR : ROW_RD_ISSUE;
                end
            end
            ROW_RD_ISSUE: state_nxt = ROW_RD_RESP;
            ROW_RD_RESP: begin
                row_rsp_valid = 1'b1;
                if (row_rsp_ready) state_nxt = ROW_IDLE;
            end
            ROW_WR:  state_nxt = ROW_IDLE;
            default: state_nxt = ROW_IDLE;
        endcase
    end

    assign is_wr    = (state == ROW_WR);
    assign row_busy = is_wr || (state == ROW_RD_ISSUE);
    // The handshake cycle also stalls B so the row engine owns port B
    // in the very next cycle without a conflict check.
    assign b_stall  = row_busy || row_hs;
    assign b_wr_ok  = b_we && !b_stall;
    assign b_rd_ok  = b_rd_en && !b_stall;

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic              a_hit, b_hit, bank_b_en, bank_b_we;
        logic [IDX_W-1:0]  bank_b_idx;
        logic [DATA_W-1:0] bank_b_wdata;

        assign a_hit        = (a_addr[BANK_BITS-1:0] == BANK_BITS'(g));
        assign b_hit        = (b_addr[BANK_BITS-1:0] == BANK_BITS'(g));
        assign bank_b_en    = row_busy || ((b_wr_ok || b_rd_ok) && b_hit);
        assign bank_b_we    = is_wr || (b_wr_ok && b_hit);
        assign bank_b_idx   = row_busy ? row_addr_q : b_addr[ADDR_W-1:BANK_BITS];
        assign bank_b_wdata = row_busy ? row_wdata_q[ROW_W-1-g*DATA_W -: DATA_W] : b_wdata;
        assign row_cat[ROW_W-1-g*DATA_W -: DATA_W] = b_q[g];

        memory_bank_dp #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_bank (
            .clock   (clock),
            .a_en    (a_rd_en && a_hit),
            .a_idx   (a_addr[ADDR_W-1:BANK_BITS]),
            .a_q     (a_q[g]),
            .b_en    (bank_b_en),
            .b_we    (bank_b_we),
            .b_idx   (bank_b_idx),
            .b_wdata (bank_b_wdata),
            .b_q     (b_q[g])
        );
    end

    // Bank output registers are shared between consumers (B and the row
    // engine), so each output keeps its own hold copy of the last valid data.
    assign a_data    = a_valid   ? a_q[a_sel_q] : a_hold;
    assign b_data    = b_valid   ? b_q[b_sel_q] : b_hold;
    assign row_rdata = rsp_first ? row_cat      : row_hold;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_valid     <= 1'b0;
            b_valid     <= 1'b0;
            a_sel_q     <= '0;
            b_sel_q     <= '0;
            a_hold      <= '0;
            b_hold      <= '0;
            row_hold    <= '0;
            rsp_first   <= 1'b0;
            row_addr_q  <= '0;
            row_wdata_q <= '0;
        end else begin
            a_valid   <= a_rd_en;
            b_valid   <= b_rd_ok;
            rsp_first <= (state == ROW_RD_ISSUE);
            if (a_rd_en)   a_sel_q  <= a_addr[BANK_BITS-1:0];
            if (b_rd_ok)   b_sel_q  <= b_addr[BANK_BITS-1:0];
            if (a_valid)   a_hold   <= a_q[a_sel_q];
            if (b_valid)   b_hold   <= b_q[b_sel_q];
            if (rsp_first) row_hold <= row_cat;
            if (row_hs) begin
                row_addr_q  <= row_req_addr;
                row_wdata_q <= row_wdata;
            end
        end
    end
endmodule

// File: tb/tb_memory_banked_row.sv
// Directed bench for memory_banked_row: a vector table for word-port
// traffic plus hand-written row-engine, stall and reset sequences.
module tb_memory_banked_row;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_rd_en, a_valid, b_rd_en, b_we, b_stall, b_valid;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_data, b_wdata, b_data;
    logic        row_req_valid, row_req_ready, row_req_write, row_rsp_valid, row_rsp_ready;
    logic [9:0]  row_req_addr;
    logic [63:0] row_wdata, row_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    memory_banked_row dut (
        .clock(clock), .reset_n(reset_n),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_valid(a_valid), .a_data(a_data),
        .b_rd_en(b_rd_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_stall(b_stall), .b_valid(b_valid), .b_data(b_data),
        .row_req_valid(row_req_valid), .row_req_ready(row_req_ready),
        .row_req_write(row_req_write), .row_req_addr(row_req_addr),
        .row_wdata(row_wdata), .row_rsp_valid(row_rsp_valid),
        .row_rsp_ready(row_rsp_ready), .row_rdata(row_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        a_rd;
        logic [11:0] a_addr;
        logic        b_rd;
        logic        b_we;
        logic [11:0] b_addr;
        logic [15:0] b_wdata;
        logic        e_stall;
        logic        e_av;
        logic [15:0] e_ad;
        logic        e_bv;
        logic [15:0] e_bd;
    } vec_t;

    vec_t vecs [10];
    logic [15:0] exp_row [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_read(input logic [11:0] addr, input logic [15:0] exp, input string nm);
        a_rd_en = 1'b1;
        a_addr  = addr;
        tick();
        a_rd_en = 1'b0;
        chk({nm, "_valid"}, 64'(a_valid), 64'd1);
        chk(nm, 64'(a_data), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           a_rd a_addr  b_rd b_we b_addr  b_wdata  stall av ad        bv bd
        vecs[0] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h005, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 12'h005, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h010, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 12'h010, 1'b1, 1'b1, 12'h010, 16'hCAFE, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[4] = '{1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 16'hCAFE, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 16'hCAFE, 1'b1, 16'hBEEF};
        vecs[6] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h013, 16'h5678, 1'b0, 1'b0, 16'hCAFE, 1'b0, 16'hBEEF};
        vecs[7] = '{1'b1, 12'h013, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b1, 16'h5678, 1'b1, 16'hCAFE};
        vecs[8] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 16'h5678, 1'b0, 16'hCAFE};
        vecs[9] = '{1'b1, 12'h005, 1'b1, 1'b0, 12'h013, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b1, 16'h5678};
        exp_row = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        reset_n = 1'b0;
        a_rd_en = 0; a_addr = 0; b_rd_en = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        row_req_valid = 0; row_req_write = 0; row_req_addr = 0; row_wdata = 0; row_rsp_ready = 0;
        #12;
        chk("rst_a_valid", 64'(a_valid), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_rsp_valid", 64'(row_rsp_valid), 64'd0);
        chk("rst_a_data", 64'(a_data), 64'd0);
        chk("rst_b_data", 64'(b_data), 64'd0);
        chk("rst_row_rdata", row_rdata, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("rst_req_ready", 64'(row_req_ready), 64'd1);

        // word-port vector table
        for (int i = 0; i < 10; i++) begin
            a_rd_en = vecs[i].a_rd;  a_addr = vecs[i].a_addr;
            b_rd_en = vecs[i].b_rd;  b_we = vecs[i].b_we;
            b_addr  = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
            #1;
            chk($sformatf("v%0d_stall", i), 64'(b_stall), 64'(vecs[i].e_stall));
            tick();
            a_rd_en = 0; b_rd_en = 0; b_we = 0;
            chk($sformatf("v%0d_a_valid", i), 64'(a_valid), 64'(vecs[i].e_av));
            chk($sformatf("v%0d_a_data", i), 64'(a_data), 64'(vecs[i].e_ad));
            chk($sformatf("v%0d_b_valid", i), 64'(b_valid), 64'(vecs[i].e_bv));
            chk($sformatf("v%0d_b_data", i), 64'(b_data), 64'(vecs[i].e_bd));
        end

        // row write row 1, then word readback
        row_req_valid = 1; row_req_write = 1; row_req_addr = 10'd1;
        row_wdata = 64'h1111_2222_3333_4444;
        #1;
        chk("rw_hs_ready", 64'(row_req_ready), 64'd1);
        chk("rw_hs_stall", 64'(b_stall), 64'd1);
        tick();
        row_req_valid = 0;
        #1;
        chk("rw_wr_ready", 64'(row_req_ready), 64'd0);
        chk("rw_wr_stall", 64'(b_stall), 64'd1);
        tick();
        chk("rw_done_ready", 64'(row_req_ready), 64'd1);
        chk("rw_done_stall", 64'(b_stall), 64'd0);
        for (int k = 0; k < 4; k++)
            a_read(12'h004 + 12'(k), exp_row[k], $sformatf("rw_rd%0d", k));

        // row read with delayed consumer; port B read slips in during RD_RESP
        row_rsp_ready = 0;
        row_req_valid = 1; row_req_write = 0; row_req_addr = 10'd1;
        tick();
        row_req_valid = 0;
        #1;
        chk("rr_issue_rsp_valid", 64'(row_rsp_valid), 64'd0);
        chk("rr_issue_ready", 64'(row_req_ready), 64'd0);
        chk("rr_issue_stall", 64'(b_stall), 64'd1);
        tick();
        chk("rr_resp_valid", 64'(row_rsp_valid), 64'd1);
        chk("rr_resp_data", row_rdata, 64'h1111_2222_3333_4444);
        b_rd_en = 1; b_addr = 12'h010;
        #1;
        chk("rr_resp_b_stall", 64'(b_stall), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            b_rd_en = 0;
            chk($sformatf("rr_hold%0d_valid", k), 64'(row_rsp_valid), 64'd1);
            chk($sformatf("rr_hold%0d_data", k), row_rdata, 64'h1111_2222_3333_4444);
            chk($sformatf("rr_hold%0d_ready", k), 64'(row_req_ready), 64'd0);
            if (k == 0) chk("rr_b_data", 64'(b_data), 64'hCAFE);
        end
        row_rsp_ready = 1;
        #1;
        chk("rr_accept_valid", 64'(row_rsp_valid), 64'd1);
        tick();
        row_rsp_ready = 0;
        chk("rr_after_valid", 64'(row_rsp_valid), 64'd0);
        chk("rr_after_ready", 64'(row_req_ready), 64'd1);
        chk("rr_after_data", row_rdata, 64'h1111_2222_3333_4444);

        // B write to 0x004 during WR: stalled, then lands on the held retry
        row_req_valid = 1; row_req_write = 1; row_req_addr = 10'd1;
        row_wdata = 64'h1111_2222_3333_4444;
        tick();
        row_req_valid = 0;
        b_we = 1; b_addr = 12'h004; b_wdata = 16'hAAAA;
        #1;
        chk("st_wr_stall", 64'(b_stall), 64'd1);
        begin
            int n;
            n = 0;
            while (b_stall && n < 8) begin
                tick();
                n++;
            end
            chk("st_stall_cycles", 64'(n), 64'd1);
        end
        a_rd_en = 1; a_addr = 12'h004;
        tick();
        b_we = 0; a_rd_en = 0;
        chk("st_rbw_a_data", 64'(a_data), 64'h1111);
        a_read(12'h004, 16'hAAAA, "st_final_004");
        a_read(12'h005, 16'h2222, "st_final_005");

        // reset during RD_RESP
        row_req_valid = 1; row_req_write = 0; row_req_addr = 10'd1;
        tick();
        row_req_valid = 0;
        tick();
        chk("rs_resp_valid", 64'(row_rsp_valid), 64'd1);
        chk("rs_resp_data", row_rdata, 64'hAAAA_2222_3333_4444);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_rsp_valid", 64'(row_rsp_valid), 64'd0);
        chk("rs_rdata", row_rdata, 64'd0);
        chk("rs_req_ready", 64'(row_req_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("rs_idle_stall", 64'(b_stall), 64'd0);
        a_read(12'h004, 16'hAAAA, "rs_mem_004");
        a_read(12'h007, 16'h4444, "rs_mem_007");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
